// File: rtl/pwm_ramp_ctrl.sv
// ============================================================================
// Module      : pwm_ramp_ctrl
// Description : Soft-start/fade sequencer that slews the PWM duty toward a
//               commanded target, changing it only on PWM period boundaries.
//               Optional feature macro: PWM_RAMP_RETARGET_EN (accept commands
//               while ramping and retarget from the current duty).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_ramp_ctrl #(
    parameter int R  = 10,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   dvsr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [R:0]    cmd_target,
    input  logic [R-1:0]  cmd_step,
    input  logic [RW-1:0] cmd_rate,
    output logic [R:0]    duty_out,
    output logic          busy,
    output logic          done,
    output logic          period_end
);

    localparam logic [1:0]   S_IDLE     = 2'd0;
    localparam logic [1:0]   S_UP       = 2'd1;
    localparam logic [1:0]   S_DOWN     = 2'd2;
    localparam logic [R:0]   DUTY_MAX   = {1'b1, {R{1'b0}}};
    localparam logic [R-1:0] PHASE_LAST = '1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   q_q, q_d;
    logic [R-1:0]  phase_q, phase_d;
    logic [RW-1:0] pcnt_q, pcnt_d;
    logic [RW-1:0] rate_q, rate_d;
    logic [R-1:0]  step_q, step_d;
    logic [R:0]    tgt_q, tgt_d;
    logic [R:0]    duty_q, duty_d;
    logic          done_q, done_d;

    logic          tick;
    logic          accept;
    logic [R:0]    tgt_new;
    logic [R+1:0]  up_sum;
    logic [R:0]    up_val;
    logic [R:0]    down_gap;
    logic [R:0]    down_val;
    logic [R:0]    stepped;

    // Timebase mirrors the PWM generator so period_end lines up with its wrap
    assign tick       = (q_q == 32'd0);
    assign period_end = tick & (phase_q == PHASE_LAST);
    assign q_d        = (q_q == dvsr) ? 32'd0 : q_q + 32'd1;
    assign phase_d    = tick ? phase_q + 1'b1 : phase_q;

    assign accept  = cmd_valid & cmd_ready;
    assign tgt_new = (cmd_target > DUTY_MAX) ? DUTY_MAX : cmd_target;

    // Extra headroom bit keeps duty+step from wrapping before the clamp
    assign up_sum   = {1'b0, duty_q} + {2'b00, step_q};
    assign up_val   = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[R:0];
    assign down_gap = duty_q - tgt_q;
    assign down_val = (down_gap <= {1'b0, step_q}) ? tgt_q : duty_q - {1'b0, step_q};
    assign stepped  = (state_q == S_UP) ? up_val : down_val;

    assign duty_out = duty_q;
    assign done     = done_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= 32'd0;
            phase_q <= '0;
            pcnt_q  <= '0;
            rate_q  <= '0;
            step_q  <= '0;
            tgt_q   <= '0;
            duty_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
            rate_q  <= rate_d;
            step_q  <= step_d;
            tgt_q   <= tgt_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
        end
    end

    // Next-state and ramp datapath
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        rate_d  = rate_q;
        step_d  = step_q;
        tgt_d   = tgt_q;
        duty_d  = duty_q;
        done_d  = 1'b0;
        if (accept) begin
            // A new command takes priority over a coincident step
            tgt_d  = tgt_new;
            step_d = (cmd_step == '0) ? {{(R-1){1'b0}}, 1'b1} : cmd_step;
            rate_d = (cmd_rate == '0) ? {{(RW-1){1'b0}}, 1'b1} : cmd_rate;
            pcnt_d = '0;
            if (tgt_new == duty_q) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else if (tgt_new > duty_q) begin
                state_d = S_UP;
            end else begin
                state_d = S_DOWN;
            end
        end else if ((state_q == S_UP) || (state_q == S_DOWN)) begin
            if (period_end) begin
                if (pcnt_q == rate_q - {{(RW-1){1'b0}}, 1'b1}) begin
                    pcnt_d = '0;
                    duty_d = stepped;
                    if (stepped == tgt_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == S_UP) || (state_q == S_DOWN);
`ifdef PWM_RAMP_RETARGET_EN
        cmd_ready = 1'b1;
`else
        cmd_ready = (state_q == S_IDLE);
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
// ============================================================================
// Module      : tb_pwm_ramp_ctrl
// Description : Scoreboard bench for pwm_ramp_ctrl (R=4, dvsr=0, 16-clk period).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_ramp_ctrl;

    localparam int R  = 4;
    localparam int RW = 8;

    logic          clk;
    logic          rst;
    logic [31:0]   dvsr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [R:0]    cmd_target;
    logic [R-1:0]  cmd_step;
    logic [RW-1:0] cmd_rate;
    logic [R:0]    duty_out;
    logic          busy;
    logic          done;
    logic          period_end;

    pwm_ramp_ctrl #(.R(R), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .dvsr       (dvsr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_rate   (cmd_rate),
        .duty_out   (duty_out),
        .busy       (busy),
        .done       (done),
        .period_end (period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int duty;
        int dn;
        int bsy;
        int pe;   // period_ends since previous event/accept; -1 = don't care
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pe_cnt = 0;
    int   last_duty = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", nm, act, exp_v, $time);
        end
    endfunction

    function automatic void push(input int d, input int dn, input int b, input int pe);
        exp_t e;
        e.duty = d; e.dn = dn; e.bsy = b; e.pe = pe;
        sb.push_back(e);
    endfunction

    // Monitor: an event is any duty change or a done pulse
    always @(negedge clk) begin
        exp_t e;
        if ((int'(duty_out) != last_duty) || done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: actual duty=%0d done=%0d expected none", duty_out, done);
            end else begin
                e = sb.pop_front();
                chk("ev_duty", int'(duty_out), e.duty);
                chk("ev_done", int'(done), e.dn);
                chk("ev_busy", int'(busy), e.bsy);
                if (e.pe >= 0) chk("ev_periods", pe_cnt, e.pe);
            end
            pe_cnt = 0;
        end
        last_duty = int'(duty_out);
        if (rst) pe_cnt = 0;
        else if (cmd_valid && cmd_ready) pe_cnt = 0;
        else if (period_end) pe_cnt++;
    end

    task automatic send(input int t, input int s, input int r);
        @(posedge clk); #1;
        cmd_target = (R+1)'(t);
        cmd_step   = R'(s);
        cmd_rate   = RW'(r);
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_duty(input int v);
        int n = 0;
        while ((int'(duty_out) != v) && (n < 600)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_duty", int'(duty_out), v);
    endtask

    task automatic wait_sb();
        int n = 0;
        while ((sb.size() != 0) && (n < 2000)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic period_len();
        int n = 0;
        int c0;
        @(posedge clk); #1;
        while (!period_end && (n < 40)) begin @(posedge clk); #1; n++; end
        c0 = cyc;
        n = 0;
        @(posedge clk); #1;
        while (!period_end && (n < 40)) begin @(posedge clk); #1; n++; end
        chk("period_len", cyc - c0, 16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; dvsr = 32'd0; cmd_valid = 1'b0;
        cmd_target = '0; cmd_step = '0; cmd_rate = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty", int'(duty_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", int'(cmd_ready), 1);
        period_len();
        period_len();

        // 0 -> 8, step 2, rate 1
        push(2, 0, 1, 1); push(4, 0, 1, 1); push(6, 0, 1, 1); push(8, 1, 0, 1);
        send(8, 2, 1);
        wait_sb();

        // 8 -> 3, step 2, rate 2 (last step clamped)
        push(6, 0, 1, 2); push(4, 0, 1, 2); push(3, 1, 0, 2);
        send(3, 2, 2);
        wait_sb();

        // target equal to current duty: immediate done
        push(3, 1, 0, 0);
        send(3, 1, 1);
        wait_sb();

        push(2, 0, 1, 1); push(1, 0, 1, 1); push(0, 1, 0, 1);
        send(0, 1, 1);
        wait_sb();

        // out-of-range target, zero step and rate
        for (int i = 1; i < 16; i++) push(i, 0, 1, 1);
        push(16, 1, 0, 1);
        send(20, 0, 0);
        wait_sb();

        push(1, 0, 1, 1); push(0, 1, 0, 1);
        send(0, 15, 1);
        wait_sb();

        // command while ramping
        push(2, 0, 1, 1); push(4, 0, 1, 1);
`ifdef PWM_RAMP_RETARGET_EN
        push(2, 0, 1, 1); push(0, 1, 0, 1);
`else
        push(6, 0, 1, 1); push(8, 1, 0, 1);
`endif
        send(8, 2, 1);
        wait_duty(4);
        cmd_target = '0; cmd_step = 4'd2; cmd_rate = 8'd1; cmd_valid = 1'b1;
        #1;
`ifdef PWM_RAMP_RETARGET_EN
        chk("ready_busy", int'(cmd_ready), 1);
`else
        chk("ready_busy", int'(cmd_ready), 0);
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_sb();

`ifdef PWM_RAMP_RETARGET_EN
        push(0, 1, 0, 0);
`else
        push(0, 1, 0, 1);
`endif
        send(0, 8, 1);
        wait_sb();

        // reset mid-ramp
        push(2, 0, 1, 1); push(4, 0, 1, 1); push(6, 0, 1, 1); push(0, 0, 0, -1);
        send(10, 2, 1);
        wait_duty(6);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_duty", int'(duty_out), 0);
        chk("rst_mid_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", int'(cmd_ready), 1);
        chk("post_rst_busy", int'(busy), 0);
        wait_sb();

        push(1, 1, 0, 1);
        send(1, 1, 1);
        wait_sb();

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
